// File: rtl/pc_fetch_ctrl.sv
// PC and fetch-control stage feeding the instruction ROM address/CE.
// Optional: define FETCH_ALIGN_CHECK_EN to flag misaligned redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [31:0]        new_pc,
  input  logic               branch_flag_i,
  input  logic [31:0]        branch_target_address_i,
  output logic [31:0]        pc_o,
  output logic               ce_o,
  output logic [31:0]        fetch_cnt_o,
  output logic               fetch_adel_o
);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    STALLED
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] ptgt_q, ptgt_d;
  logic        redir;
  logic [31:0] raddr;
  logic        stall_pc;

  // Only the PC-stage bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^stall;
  assign stall_pc     = stall[0];

`ifdef FETCH_ALIGN_CHECK_EN
  logic adel_q, adel_d;
`endif

  // Next-state: redirect priority flush > stall > pending > branch > +4.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ce_d    = ce_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ptgt_d  = ptgt_q;
    redir   = 1'b0;
    raddr   = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    adel_d  = adel_q;
`endif

    if (ce_q && !stall_pc) begin
      cnt_d = cnt_q + 32'd1;
    end

    unique case (state_q)
      HOLD: begin
        state_d = RUN;
        ce_d    = 1'b1;
      end
      RUN, STALLED: begin
        if (flush) begin
          state_d = RUN;
          pend_d  = 1'b0;
          redir   = 1'b1;
          raddr   = new_pc;
          ce_d    = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
          adel_d  = 1'b0;
        end else if (adel_q) begin
          // Faulted fetch stays parked until a flush.
          state_d = stall_pc ? STALLED : RUN;
`endif
        end else if (stall_pc) begin
          state_d = STALLED;
          if (branch_flag_i) begin
            pend_d = 1'b1;
            ptgt_d = branch_target_address_i;
          end
        end else begin
          state_d = RUN;
          if (pend_q) begin
            pend_d = 1'b0;
            redir  = 1'b1;
            raddr  = ptgt_q;
          end else if (branch_flag_i) begin
            redir = 1'b1;
            raddr = branch_target_address_i;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    if (redir) begin
`ifdef FETCH_ALIGN_CHECK_EN
      pc_d   = raddr;
      adel_d = |raddr[1:0];
      ce_d   = ~|raddr[1:0];
`else
      pc_d   = {raddr[31:2], 2'b00};
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      pc_q    <= RESET_PC;
      ce_q    <= 1'b0;
      cnt_q   <= 32'd0;
      pend_q  <= 1'b0;
      ptgt_q  <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= ce_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_q  <= adel_d;
`endif
    end
  end

  assign pc_o        = pc_q;
  assign ce_o        = ce_q;
  assign fetch_cnt_o = cnt_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_adel_o = adel_q;
`else
  assign fetch_adel_o = 1'b0;
`endif

endmodule
